traffic_light_fsm: RTL and testbench

Sequencing controller for the intersection. Drives main-road, side-road and optional pedestrian lamps, and owns the shared seconds timer: it loads an interval value, pulses a start strobe on every state entry, then advances when the timer reports expiry. Sits between the synchronised sensor/button inputs and the lamp drivers, alongside the 1 Hz enable generator and the timer.

---
 rtl/traffic_light_fsm.sv | 178 +++++++++++++++++
 tb/tb_traffic_light_fsm.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_fsm.sv
// Intersection sequencer: lamps, shared seconds-timer load/start, request latches.
// Optional pedestrian WALK phase built only when TLC_WALK_EN is defined.
module traffic_light_fsm #(
   parameter int unsigned T_BASE = 6,
   parameter int unsigned T_EXT  = 3,
   parameter int unsigned T_YEL  = 2,
   parameter int unsigned T_WALK = 5
) (
   input  logic       clk,
   input  logic       Reset_Sync,
   input  logic       sensor,
   input  logic       walk_btn,
   input  logic       expired,
   output logic [3:0] timer_value,
   output logic       start_timer,
   output logic [2:0] main_lights,
   output logic [2:0] side_lights,
   output logic       walk_lamp,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      MAIN_GREEN  = 3'd0,
      MAIN_YELLOW = 3'd1,
      SIDE_GREEN  = 3'd2,
      SIDE_YELLOW = 3'd3
`ifdef TLC_WALK_EN
      , WALK      = 3'd4
`endif
   } state_e;

   localparam logic [3:0] TV_BASE = 4'(T_BASE);
   localparam logic [3:0] TV_EXT  = 4'(T_EXT);
   localparam logic [3:0] TV_YEL  = 4'(T_YEL);
`ifdef TLC_WALK_EN
   localparam logic [3:0] TV_WALK = 4'(T_WALK);
`endif

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   state_e     state_q, state_d;
   logic [3:0] tv_q, tv_d;
   logic       start_q, start_d;
   logic [2:0] main_q, main_d;
   logic [2:0] side_q, side_d;
   logic       walk_q, walk_d;
   logic       side_req_q, side_req_d;
   logic       walk_req_q, walk_req_d;
   logic       ext_q, ext_d;
   logic       exp_q, exp_d;
   logic       go;

`ifndef TLC_WALK_EN
   logic unused_walk_btn;
   assign unused_walk_btn = walk_btn;
`endif

   always_comb begin
      state_d    = state_q;
      tv_d       = tv_q;
      start_d    = 1'b0;
      main_d     = main_q;
      side_d     = side_q;
      walk_d     = walk_q;
      ext_d      = ext_q;
      // Expiry seen while start_timer is high belongs to the old interval.
      exp_d      = expired & ~start_q & ~exp_q;
      go         = exp_q;

      if (go) begin
         unique case (state_q)
            MAIN_GREEN:
               state_d = (side_req_q | walk_req_q) ? MAIN_YELLOW : MAIN_GREEN;
            MAIN_YELLOW: begin
`ifdef TLC_WALK_EN
               state_d = walk_req_q ? WALK : SIDE_GREEN;
`else
               state_d = SIDE_GREEN;
`endif
            end
            SIDE_GREEN: begin
               if (sensor && !ext_q) begin
                  state_d = SIDE_GREEN;
                  ext_d   = 1'b1;
               end else begin
                  state_d = SIDE_YELLOW;
                  ext_d   = 1'b0;
               end
            end
            SIDE_YELLOW:
               state_d = MAIN_GREEN;
`ifdef TLC_WALK_EN
            WALK:
               state_d = side_req_q ? SIDE_GREEN : MAIN_GREEN;
`endif
            default:
               state_d = MAIN_GREEN;
         endcase

         start_d = 1'b1;
         walk_d  = 1'b0;
         unique case (state_d)
            MAIN_GREEN: begin
               tv_d = TV_BASE; main_d = GRN; side_d = RED;
            end
            MAIN_YELLOW: begin
               tv_d = TV_YEL;  main_d = YEL; side_d = RED;
            end
            SIDE_GREEN: begin
               tv_d = ext_d ? TV_EXT : TV_BASE;
               main_d = RED; side_d = GRN;
            end
            SIDE_YELLOW: begin
               tv_d = TV_YEL;  main_d = RED; side_d = YEL;
            end
`ifdef TLC_WALK_EN
            WALK: begin
               tv_d = TV_WALK; main_d = RED; side_d = RED;
               walk_d = 1'b1;
            end
`endif
            default: begin
               tv_d = TV_BASE; main_d = GRN; side_d = RED;
            end
         endcase
      end

      // Set beats a coincident clear on entry.
      side_req_d = sensor |
                   (side_req_q & ~(go && state_d == SIDE_GREEN));
`ifdef TLC_WALK_EN
      walk_req_d = walk_btn |
                   (walk_req_q & ~(go && state_d == WALK));
`else
      walk_req_d = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (Reset_Sync) begin
         state_q    <= MAIN_GREEN;
         tv_q       <= TV_BASE;
         start_q    <= 1'b1;
         main_q     <= GRN;
         side_q     <= RED;
         walk_q     <= 1'b0;
         side_req_q <= 1'b0;
         walk_req_q <= 1'b0;
         ext_q      <= 1'b0;
         exp_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tv_q       <= tv_d;
         start_q    <= start_d;
         main_q     <= main_d;
         side_q     <= side_d;
         walk_q     <= walk_d;
         side_req_q <= side_req_d;
         walk_req_q <= walk_req_d;
         ext_q      <= ext_d;
         exp_q      <= exp_d;
      end
   end

   assign timer_value = tv_q;
   assign start_timer = start_q;
   assign main_lights = main_q;
   assign side_lights = side_q;
`ifdef TLC_WALK_EN
   assign walk_lamp   = walk_q;
`else
   assign walk_lamp   = 1'b0;
`endif
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboarded bench for traffic_light_fsm; expectations follow TLC_WALK_EN.
// Expected entries are queued at each expiry and retired on start_timer.
module tb_traffic_light_fsm;

   logic       clk = 1'b0;
   logic       Reset_Sync = 1'b1;
   logic       sensor = 1'b0;
   logic       walk_btn = 1'b0;
   logic       expired = 1'b0;
   logic [3:0] timer_value;
   logic       start_timer;
   logic [2:0] main_lights;
   logic [2:0] side_lights;
   logic       walk_lamp;
   logic [2:0] state_dbg;

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      logic [2:0] st;
      logic [3:0] tv;
   } exp_t;

   exp_t sb[$];

   traffic_light_fsm dut (
      .clk         (clk),
      .Reset_Sync  (Reset_Sync),
      .sensor      (sensor),
      .walk_btn    (walk_btn),
      .expired     (expired),
      .timer_value (timer_value),
      .start_timer (start_timer),
      .main_lights (main_lights),
      .side_lights (side_lights),
      .walk_lamp   (walk_lamp),
      .state_dbg   (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp,
                  $time);
      end
   endtask

   // Lamp table by state code: {main, side, walk}
   function automatic logic [6:0] lamps(input logic [2:0] st);
      case (st)
         3'd0:    return {3'b001, 3'b100, 1'b0};
         3'd1:    return {3'b010, 3'b100, 1'b0};
         3'd2:    return {3'b100, 3'b001, 1'b0};
         3'd3:    return {3'b100, 3'b010, 1'b0};
         3'd4:    return {3'b100, 3'b100, 1'b1};
         default: return 7'h7f;
      endcase
   endfunction

   always @(negedge clk) begin
      check("main_onehot", 32'($onehot(main_lights)), 32'd1);
      check("side_onehot", 32'($onehot(side_lights)), 32'd1);
      check("no_conflict",
            32'(main_lights != 3'b100 && side_lights != 3'b100), 32'd0);
   end

   task automatic pulse_req(input logic s, input logic w);
      @(negedge clk);
      sensor   = s;
      walk_btn = w;
      @(negedge clk);
      sensor   = 1'b0;
      walk_btn = 1'b0;
   endtask

   task automatic pulse_exp(input logic s, input logic [2:0] st,
                            input logic [3:0] tv);
      exp_t e;
      int lat;
      logic [6:0] l;
      e.st = st;
      e.tv = tv;
      sb.push_back(e);
      @(negedge clk);
      expired = 1'b1;
      sensor  = s;
      @(negedge clk);
      expired = 1'b0;
      lat = 0;
      while (lat < 8) begin
         @(negedge clk);
         lat++;
         if (start_timer) break;
      end
      sensor = 1'b0;
      e = sb.pop_front();
      if (!start_timer) begin
         check("start_timeout", 32'd0, 32'd1);
      end else begin
         l = lamps(e.st);
         check("latency", 32'(lat), 32'd1);
         check("state", 32'(state_dbg), 32'(e.st));
         check("timer_value", 32'(timer_value), 32'(e.tv));
         check("main", 32'(main_lights), 32'(l[6:4]));
         check("side", 32'(side_lights), 32'(l[3:1]));
         check("walk", 32'(walk_lamp), 32'(l[0]));
         @(negedge clk);
         check("start_one_cycle", 32'(start_timer), 32'd0);
         check("state_hold", 32'(state_dbg), 32'(e.st));
      end
   endtask

   initial begin
      int n_start;
      repeat (2) @(negedge clk);
      check("rst_state", 32'(state_dbg), 32'd0);
      check("rst_main", 32'(main_lights), 32'b001);
      check("rst_side", 32'(side_lights), 32'b100);
      check("rst_walk", 32'(walk_lamp), 32'd0);
      check("rst_tv", 32'(timer_value), 32'd6);
      check("rst_start", 32'(start_timer), 32'd1);

      // Stale expiry coincident with start_timer
      Reset_Sync = 1'b0;
      expired    = 1'b1;
      @(negedge clk);
      expired = 1'b0;
      n_start = 0;
      repeat (5) begin
         @(negedge clk);
         if (start_timer) n_start++;
      end
      check("stale_start", 32'(n_start), 32'd0);
      check("stale_state", 32'(state_dbg), 32'd0);

      // Idle road
      repeat (3) pulse_exp(1'b0, 3'd0, 4'd6);

      // Side request
      pulse_req(1'b1, 1'b0);
      pulse_exp(1'b0, 3'd1, 4'd2);
      pulse_exp(1'b0, 3'd2, 4'd6);
      pulse_exp(1'b0, 3'd3, 4'd2);
      pulse_exp(1'b0, 3'd0, 4'd6);
      pulse_exp(1'b0, 3'd0, 4'd6);

      // Extension, one per visit
      pulse_req(1'b1, 1'b0);
      pulse_exp(1'b0, 3'd1, 4'd2);
      pulse_exp(1'b0, 3'd2, 4'd6);
      pulse_exp(1'b1, 3'd2, 4'd3);
      pulse_exp(1'b1, 3'd3, 4'd2);
      pulse_exp(1'b0, 3'd0, 4'd6);
      // sensor during the last extension expiry left a request pending
      pulse_exp(1'b0, 3'd1, 4'd2);
      pulse_exp(1'b0, 3'd2, 4'd6);
      pulse_exp(1'b0, 3'd3, 4'd2);
      pulse_exp(1'b0, 3'd0, 4'd6);

      // Walk request together with side request
      pulse_req(1'b1, 1'b1);
      pulse_exp(1'b0, 3'd1, 4'd2);
`ifdef TLC_WALK_EN
      pulse_exp(1'b0, 3'd4, 4'd5);
      pulse_exp(1'b0, 3'd2, 4'd6);
`else
      pulse_exp(1'b0, 3'd2, 4'd6);
`endif
      pulse_exp(1'b0, 3'd3, 4'd2);
      pulse_exp(1'b0, 3'd0, 4'd6);

      // Reset in SIDE_YELLOW
      pulse_req(1'b1, 1'b0);
      pulse_exp(1'b0, 3'd1, 4'd2);
      pulse_exp(1'b0, 3'd2, 4'd6);
      pulse_exp(1'b0, 3'd3, 4'd2);
      Reset_Sync = 1'b1;
      @(negedge clk);
      Reset_Sync = 1'b0;
      check("mid_rst_state", 32'(state_dbg), 32'd0);
      check("mid_rst_main", 32'(main_lights), 32'b001);
      check("mid_rst_side", 32'(side_lights), 32'b100);
      check("mid_rst_tv", 32'(timer_value), 32'd6);
      check("mid_rst_start", 32'(start_timer), 32'd1);
      @(negedge clk);
      check("mid_rst_start_drop", 32'(start_timer), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
